// File: rtl/dsd_timer_pkg.sv
// dsd_timer_pkg: shared constants for the multi-channel interval timer.
//   - Register offsets inside one channel's 8-word window.
//   - CONTROL and STATUS bit positions.
package dsd_timer_pkg;

   // Register offsets within a channel window
   localparam logic [2:0] OFF_STATUS   = 3'd0;
   localparam logic [2:0] OFF_CONTROL  = 3'd1;
   localparam logic [2:0] OFF_PERIOD   = 3'd2;
   localparam logic [2:0] OFF_COMPARE  = 3'd3;
   localparam logic [2:0] OFF_SNAPSHOT = 3'd4;
   localparam logic [2:0] OFF_SNAP_ALL = 3'd5;

   // CONTROL bits (START/STOP are write-only strobes)
   localparam int unsigned CTL_ITO    = 0;
   localparam int unsigned CTL_CONT   = 1;
   localparam int unsigned CTL_START  = 2;
   localparam int unsigned CTL_STOP   = 3;
   localparam int unsigned CTL_PWM_EN = 4;

   // STATUS bits
   localparam int unsigned ST_TO  = 0;
   localparam int unsigned ST_RUN = 1;

endpackage

// File: rtl/dsd_timer_channel.sv
// dsd_timer_channel: one down-counting timer channel.
//   Holds counter, PERIOD, CONTROL, RUN/TO status, snapshot and (optionally) PWM compare.
//   Optional feature macro: DSD_TIMER_PWM_EN builds COMPARE, PWM_EN and the PWM output.
// Ports:
//   clk_i, reset_i   clock, asynchronous active-high reset
//   wr_i             bus write addressed to this channel
//   off_i            register offset (used for both write and read select)
//   wdata_i          write data, already truncated to CNT_W
//   snap_all_i       capture count into snapshot (global SNAP_ALL write)
//   rdata_o          combinational read value of the register at off_i
//   irq_o            TO && ITO
//   pwm_o            registered PWM output
module dsd_timer_channel
   import dsd_timer_pkg::*;
#(
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned RESET_PERIOD = 49999
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             wr_i,
   input  logic [2:0]       off_i,
   input  logic [CNT_W-1:0] wdata_i,
   input  logic             snap_all_i,
   output logic [CNT_W-1:0] rdata_o,
   output logic             irq_o,
   output logic             pwm_o
);

   logic [CNT_W-1:0] count_q, count_d, period_q, snap_q;
   logic             run_q, run_d, to_q, to_d;
   logic             ito_q, cont_q, reload_q, nz_prev_q;
   logic [CNT_W-1:0] cmp_val;
   logic             pwm_en_val, pwm_val;

   logic wr_status, wr_ctrl, wr_period, wr_snap;
   logic start, stop, run_cmd, advance, cnt_zero, timeout;

   assign wr_status = wr_i && (off_i == OFF_STATUS);
   assign wr_ctrl   = wr_i && (off_i == OFF_CONTROL);
   assign wr_period = wr_i && (off_i == OFF_PERIOD);
   assign wr_snap   = wr_i && (off_i == OFF_SNAPSHOT);

   assign start    = wr_ctrl && wdata_i[CTL_START];
   assign stop     = wr_ctrl && wdata_i[CTL_STOP];
   // Strobes already act on this edge; START beats STOP.
   assign run_cmd  = start || (run_q && !stop);
   assign advance  = run_cmd || reload_q;
   assign cnt_zero = (count_q == '0);
   // Only the first cycle at zero counts as a timeout.
   assign timeout  = cnt_zero && nz_prev_q;

   always_comb begin
      count_d = count_q;
      if (advance) begin
         count_d = (reload_q || cnt_zero) ? period_q : count_q - 1'b1;
      end

      run_d = run_q;
      if (start) begin
         run_d = 1'b1;
      end else if (stop || wr_period || reload_q || (advance && cnt_zero && !cont_q)) begin
         run_d = 1'b0;
      end

      // A timeout in the same cycle as a STATUS write keeps TO set.
      to_d = timeout ? 1'b1 : (wr_status ? 1'b0 : to_q);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count_q   <= CNT_W'(RESET_PERIOD);
         period_q  <= CNT_W'(RESET_PERIOD);
         snap_q    <= '0;
         run_q     <= 1'b0;
         to_q      <= 1'b0;
         ito_q     <= 1'b0;
         cont_q    <= 1'b0;
         reload_q  <= 1'b0;
         nz_prev_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         run_q     <= run_d;
         to_q      <= to_d;
         reload_q  <= wr_period;
         nz_prev_q <= !cnt_zero;
         if (wr_period) begin
            period_q <= wdata_i;
         end
         if (wr_ctrl) begin
            ito_q  <= wdata_i[CTL_ITO];
            cont_q <= wdata_i[CTL_CONT];
         end
         if (wr_snap || snap_all_i) begin
            snap_q <= count_q;
         end
      end
   end

`ifdef DSD_TIMER_PWM_EN
   logic [CNT_W-1:0] cmp_q;
   logic             pwm_en_q, pwm_q, wr_cmp;

   assign wr_cmp = wr_i && (off_i == OFF_COMPARE);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cmp_q    <= '0;
         pwm_en_q <= 1'b0;
         pwm_q    <= 1'b0;
      end else begin
         if (wr_cmp) begin
            cmp_q <= wdata_i;
         end
         if (wr_ctrl) begin
            pwm_en_q <= wdata_i[CTL_PWM_EN];
         end
         pwm_q <= pwm_en_q && run_q && (count_q < cmp_q);
      end
   end

   assign cmp_val    = cmp_q;
   assign pwm_en_val = pwm_en_q;
   assign pwm_val    = pwm_q;
`else
   assign cmp_val    = '0;
   assign pwm_en_val = 1'b0;
   assign pwm_val    = 1'b0;
`endif

   always_comb begin
      rdata_o = '0;
      case (off_i)
         OFF_STATUS: begin
            rdata_o[ST_TO]  = to_q;
            rdata_o[ST_RUN] = run_q;
         end
         OFF_CONTROL: begin
            rdata_o[CTL_ITO]    = ito_q;
            rdata_o[CTL_CONT]   = cont_q;
            rdata_o[CTL_PWM_EN] = pwm_en_val;
         end
         OFF_PERIOD:   rdata_o = period_q;
         OFF_COMPARE:  rdata_o = cmp_val;
         OFF_SNAPSHOT: rdata_o = snap_q;
         default:      rdata_o = '0;
      endcase
   end

   assign irq_o = to_q && ito_q;
   assign pwm_o = pwm_val;

endmodule

// File: rtl/dsd_sys_multi_timer.sv
// dsd_sys_multi_timer: N_CH-channel interval timer on an Avalon-MM slave.
//   Decodes {channel, offset} addresses, fans writes out to the channels and registers
//   the read mux every cycle. Optional feature macro: DSD_TIMER_PWM_EN (PWM compare).
// Ports:
//   clk_i, reset_i     clock, asynchronous active-high reset
//   address_i          {channel, offset[2:0]}
//   chipselect_i       slave select
//   write_n_i          active-low write strobe
//   writedata_i        write data
//   readdata_o         registered read data (1-cycle latency, chipselect-independent)
//   irq_o              OR of irq_vec_o
//   irq_vec_o          per-channel interrupt
//   pwm_out_o          per-channel PWM output (0 when PWM is not built)
module dsd_sys_multi_timer
   import dsd_timer_pkg::*;
#(
   parameter int unsigned N_CH         = 4,
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned RESET_PERIOD = 49999
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [$clog2(N_CH)+2:0] address_i,
   input  logic                    chipselect_i,
   input  logic                    write_n_i,
   input  logic [DATA_W-1:0]       writedata_i,
   output logic [DATA_W-1:0]       readdata_o,
   output logic                    irq_o,
   output logic [N_CH-1:0]         irq_vec_o,
   output logic [N_CH-1:0]         pwm_out_o
);

   localparam int unsigned AW = $clog2(N_CH) + 3;

   logic [AW-1:0]     chan;
   logic [2:0]        off;
   logic              wr_en, snap_all;
   logic [CNT_W-1:0]  wdata;
   logic [CNT_W-1:0]  ch_rdata [N_CH];
   logic [DATA_W-1:0] rd_sel, readdata_q;

   assign chan     = address_i >> 3;
   assign off      = address_i[2:0];
   assign wr_en    = chipselect_i && !write_n_i;
   assign wdata    = writedata_i[CNT_W-1:0];
   // Writes to a channel index beyond N_CH are ignored, including SNAP_ALL.
   assign snap_all = wr_en && (chan < AW'(N_CH)) && (off == OFF_SNAP_ALL);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic wr_ch;
      assign wr_ch = wr_en && (chan == AW'(i));

      dsd_timer_channel #(
         .CNT_W        (CNT_W),
         .RESET_PERIOD (RESET_PERIOD)
      ) u_ch (
         .clk_i      (clk_i),
         .reset_i    (reset_i),
         .wr_i       (wr_ch),
         .off_i      (off),
         .wdata_i    (wdata),
         .snap_all_i (snap_all),
         .rdata_o    (ch_rdata[i]),
         .irq_o      (irq_vec_o[i]),
         .pwm_o      (pwm_out_o[i])
      );
   end

   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (chan == AW'(i)) begin
            rd_sel = DATA_W'(ch_rdata[i]);
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         readdata_q <= '0;
      end else begin
         readdata_q <= rd_sel;
      end
   end

   assign readdata_o = readdata_q;
   assign irq_o      = |irq_vec_o;

endmodule

// File: tb/tb_dsd_sys_multi_timer.sv
// Self-checking bench for dsd_sys_multi_timer: directed scenarios followed by random bus
// traffic, all compared cycle by cycle against a behavioural model of the register map.
module tb_dsd_sys_multi_timer;

   localparam int unsigned N_CH         = 4;
   localparam int unsigned CNT_W        = 32;
   localparam int unsigned DATA_W       = 32;
   localparam int unsigned RESET_PERIOD = 49999;
   localparam int unsigned AW           = 5;
`ifdef DSD_TIMER_PWM_EN
   localparam bit PWM = 1'b1;
`else
   localparam bit PWM = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [AW-1:0]     address;
   logic              chipselect, write_n;
   logic [DATA_W-1:0] writedata, readdata;
   logic              irq;
   logic [N_CH-1:0]   irq_vec, pwm_out;

   always #5 clk = ~clk;

   dsd_sys_multi_timer #(
      .N_CH         (N_CH),
      .CNT_W        (CNT_W),
      .DATA_W       (DATA_W),
      .RESET_PERIOD (RESET_PERIOD)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .address_i    (address),
      .chipselect_i (chipselect),
      .write_n_i    (write_n),
      .writedata_i  (writedata),
      .readdata_o   (readdata),
      .irq_o        (irq),
      .irq_vec_o    (irq_vec),
      .pwm_out_o    (pwm_out)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Behavioural model of the register map
   logic [CNT_W-1:0]  m_cnt [N_CH];
   logic [CNT_W-1:0]  m_per [N_CH];
   logic [CNT_W-1:0]  m_cmp [N_CH];
   logic [CNT_W-1:0]  m_snap[N_CH];
   bit                m_ito[N_CH], m_cont[N_CH], m_pen[N_CH], m_run[N_CH], m_to[N_CH];
   bit                m_rl[N_CH], m_nz[N_CH], m_pwm[N_CH];
   logic [DATA_W-1:0] m_rd;
   logic [31:0]       rst_exp [5];

   task automatic m_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_cnt[c] = RESET_PERIOD;  m_per[c] = RESET_PERIOD;
         m_cmp[c] = '0;            m_snap[c] = '0;
         m_ito[c] = 0; m_cont[c] = 0; m_pen[c] = 0; m_run[c] = 0; m_to[c] = 0;
         m_rl[c] = 0;  m_nz[c] = 0;   m_pwm[c] = 0;
      end
      m_rd = '0;
   endtask

   function automatic logic [31:0] m_read(input int ch, input int off);
      if (ch >= N_CH) return 0;
      case (off)
         0:       return {30'b0, m_run[ch], m_to[ch]};
         1:       return {27'b0, m_pen[ch], 2'b0, m_cont[ch], m_ito[ch]};
         2:       return m_per[ch];
         3:       return m_cmp[ch];
         4:       return m_snap[ch];
         default: return 0;
      endcase
   endfunction

   // One clock edge of the model, using the bus inputs currently applied.
   task automatic m_edge();
      int               ch  = int'(address) >> 3;
      int               off = int'(address) & 7;
      bit               wr  = chipselect && !write_n && (ch < N_CH);
      logic [CNT_W-1:0] wd  = writedata[CNT_W-1:0];
      m_rd = m_read(ch, off);
      for (int c = 0; c < N_CH; c++) begin
         bit               w       = wr && (ch == c);
         bit               start   = w && (off == 1) && wd[2];
         bit               stop    = w && (off == 1) && wd[3];
         bit               wper    = w && (off == 2);
         bit               zero    = (m_cnt[c] == 0);
         bit               moving  = start || (m_run[c] && !stop) || m_rl[c];
         bit               timeout = zero && m_nz[c];
         logic [CNT_W-1:0] old     = m_cnt[c];
         if (PWM) m_pwm[c] = m_pen[c] && m_run[c] && (old < m_cmp[c]);
         if ((w && off == 4) || (wr && off == 5)) m_snap[c] = old;
         if (moving) m_cnt[c] = (m_rl[c] || zero) ? m_per[c] : old - 1;
         if (start) m_run[c] = 1;
         else if (stop || wper || m_rl[c] || (moving && zero && !m_cont[c])) m_run[c] = 0;
         if (timeout) m_to[c] = 1;
         else if (w && off == 0) m_to[c] = 0;
         m_nz[c] = !zero;
         m_rl[c] = wper;
         if (wper) m_per[c] = wd;
         if (w && off == 1) begin
            m_ito[c]  = wd[0];
            m_cont[c] = wd[1];
            if (PWM) m_pen[c] = wd[4];
         end
         if (PWM && w && off == 3) m_cmp[c] = wd;
      end
   endtask

   task automatic check_outputs();
      logic [N_CH-1:0] ev, ep;
      for (int c = 0; c < N_CH; c++) begin
         ev[c] = m_to[c] && m_ito[c];
         ep[c] = m_pwm[c];
      end
      check("readdata", readdata, m_rd);
      check("irq_vec", irq_vec, ev);
      check("irq", irq, |ev);
      check("pwm_out", pwm_out, ep);
   endtask

   task automatic cycle();
      @(posedge clk);
      m_edge();
      #1;
      check_outputs();
   endtask

   task automatic idle();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      address    = AW'(a);
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      cycle();
      idle();
   endtask

   task automatic rd(input int a, output logic [31:0] v);
      address = AW'(a);
      idle();
      cycle();
      v = readdata;
   endtask

   task automatic wait_irq(input string tag, input int budget);
      int n = 0;
      while (!irq && n < budget) begin
         cycle();
         n++;
      end
      check(tag, irq, 1);
   endtask

   initial begin
      logic [31:0] v;
      logic [CNT_W-1:0] exp0, exp3;
      int rises, hi, n;
      bit prev;

      rst_exp = '{32'd0, 32'd0, 32'd49999, 32'd0, 32'd0};
      reset = 1'b1;
      address = '0;
      writedata = '0;
      idle();
      #12;
      check("rst_readdata", readdata, 0);
      check("rst_irq", irq, 0);
      check("rst_irq_vec", irq_vec, 0);
      check("rst_pwm", pwm_out, 0);
      m_reset();
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         rd(i, v);
         check($sformatf("rst_off%0d", i), v, rst_exp[i]);
      end

      // ch1 continuous with interrupt
      wr(10, 9);
      wr(9, 7);
      wait_irq("ch1_first_irq", 15);
      check("ch1_irq_vec", irq_vec, 32'h2);
      wr(8, 0);
      check("ch1_to_clear", irq_vec, 0);
      wait_irq("ch1_irq_again", 12);

      // ch2 one-shot
      wr(18, 4);
      wr(17, 4);
      rises = 0;
      prev = 0;
      for (int i = 0; i < 14; i++) begin
         rd(16, v);
         if (v[0] && !prev) rises++;
         prev = v[0];
      end
      check("ch2_to_once", rises, 1);
      check("ch2_status", v, 1);
      wr(20, 0);
      rd(20, v);
      check("ch2_count_hold", v, 4);

      // STATUS write coinciding with a ch1 timeout
      wr(8, 0);
      n = 0;
      while (!(m_cnt[1] == 0 && m_nz[1]) && n < 20) begin
         cycle();
         n++;
      end
      check("ch1_event_found", n < 20, 1);
      wr(8, 0);
      rd(8, v);
      check("ch1_to_event_wins", v[0], 1);

      // START|STOP on ch3
      wr(25, 'hC);
      rd(24, v);
      check("ch3_start_stop", v[1], 1);

      // SNAP_ALL across ch0 and ch3 with different periods
      wr(2, 6);
      wr(1, 6);
      wr(26, 11);
      wr(25, 6);
      repeat (7) cycle();
      exp0 = m_cnt[0];
      exp3 = m_cnt[3];
      wr(5, 0);
      rd(4, v);
      check("snap_ch0", v, exp0);
      rd(28, v);
      check("snap_ch3", v, exp3);
      rd(5, v);
      check("snap_all_reads0", v, 0);

      // PERIOD write mid-run
      wr(2, 20);
      rd(0, v);
      check("per_stop_run", v[1], 0);
      wr(4, 0);
      rd(4, v);
      check("per_reload", v, 20);

      // PWM
`ifdef DSD_TIMER_PWM_EN
      wr(2, 9);
      wr(3, 3);
      wr(1, 'h16);
      repeat (5) cycle();
      hi = 0;
      repeat (30) begin
         cycle();
         hi += int'(pwm_out[0]);
      end
      check("pwm_duty", hi, 9);
`else
      wr(3, 3);
      rd(3, v);
      check("cmp_reads0", v, 0);
      wr(1, 'h16);
      hi = 0;
      repeat (30) begin
         cycle();
         hi += int'(pwm_out[0]);
      end
      check("pwm_tied0", hi, 0);
`endif

      // Random bus traffic
      repeat (3000) begin
         int a;
         a = $urandom_range(0, N_CH * 8 - 1);
         address    = AW'(a);
         chipselect = ($urandom_range(0, 2) == 0);
         write_n    = $urandom_range(0, 1) != 0;
         case (a % 8)
            1:       writedata = $urandom_range(0, 31);
            2:       writedata = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 15);
            3:       writedata = $urandom_range(0, 18);
            default: writedata = $urandom;
         endcase
         cycle();
      end
      idle();

      // Reset in the middle of activity
      #2;
      reset = 1'b1;
      #1;
      check("rst_mid_readdata", readdata, 0);
      check("rst_mid_irq", irq, 0);
      check("rst_mid_irq_vec", irq_vec, 0);
      check("rst_mid_pwm", pwm_out, 0);
      m_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) cycle();
      rd(8, v);
      check("rst_no_restart", v, 0);
      rd(10, v);
      check("rst_period", v, RESET_PERIOD);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/dsd_sys_multi_timer.md
# dsd_sys_multi_timer

Parametrised multi-channel interval timer on the system Avalon-MM bus, the next generation of the single-channel system clock timer. It provides N_CH independent down-counters of CNT_W bits, each with one-shot/continuous mode, a snapshot register and an optional PWM compare output. Per-channel and combined interrupts go to the Nios II IRQ inputs; PWM outputs go to board I/O.

## Interface
- N_CH, 4: number of channels (1..16)
- CNT_W, 32: counter/period/compare width (8..32)
- DATA_W, 32: bus data width (≥ CNT_W)
- RESET_PERIOD, 49999: reset value of every period register and counter (1 ms at 50 MHz)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  $clog2(N_CH)+3  {channel, offset[2:0]}
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  DATA_W  write data
- readdata  out  DATA_W  registered read data
- irq  out  1  OR of irq_vec
- irq_vec  out  N_CH  per-channel interrupt
- pwm_out  out  N_CH  per-channel PWM output

## Operation
- Write = chipselect && !write_n. Offsets per channel:
  - 0 STATUS: bit0 TO (timeout), bit1 RUN (read-only). Any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit4 PWM_EN are stored. Bit2 START and bit3 STOP are strobes, read back as 0.
  - 2 PERIOD: load value, CNT_W bits. A write also forces reload and stops the counter.
  - 3 COMPARE: PWM threshold, CNT_W bits.
  - 4 SNAPSHOT: a write captures this channel's count; a read returns the captured value.
  - 5 SNAP_ALL: a write captures all channels in the same cycle; reads as 0.
  - 6, 7: read as 0; writes ignored.
- Counter (when RUN=1 or a forced reload is pending):
  - force_reload or count==0 → count ← PERIOD; otherwise count−1.
  - Period of timeout is PERIOD+1 cycles.
- RUN control:
  - START sets RUN.
  - Clears on STOP, on force_reload, or on count==0 with CONT=0.
  - START wins over STOP in the same write.
- Timeout event = count==0 with count!=0 in the previous cycle. It sets TO.
  - Event in the same cycle as a STATUS write: TO remains set (event wins).
- irq_vec[i] = TO[i] && ITO[i]. irq = |irq_vec.
- pwm_out[i] (registered) = PWM_EN && RUN && (count < COMPARE).
  - COMPARE=0 → output always low.
  - COMPARE>PERIOD → output always high while RUN=1.
- Write data above CNT_W bits is ignored. Those bits read as 0.
- Channel index ≥ N_CH: reads return 0; writes ignored.

## Timing
- Reset values:
  - readdata=0, irq=0, irq_vec=0, pwm_out=0.
  - count=PERIOD=RESET_PERIOD; COMPARE=0, CONTROL=0, TO=0, RUN=0, snapshots=0.
- Read latency: readdata is valid 1 cycle after address. readdata is updated every cycle, independent of chipselect.
- Register writes take effect at the clock edge of the write. Strobes act on the counter in the same edge.
- Forced reload happens 1 cycle after a PERIOD write. RUN=0 from that same cycle.
- TO is set at the edge after count reaches 0. irq follows combinationally from TO/ITO.
- pwm_out lags count by 1 cycle.
- Reset asserted mid-count returns every register to its reset value immediately. Nothing restarts until START.

## Configuration
- DSD_TIMER_PWM_EN defined:
  - COMPARE register, PWM_EN bit and pwm_out logic are built.
- DSD_TIMER_PWM_EN undefined:
  - COMPARE and PWM_EN read 0 and ignore writes.
  - pwm_out is tied to 0; the port remains for interface stability.

## Structure
- Package dsd_timer_pkg holds:
  - offset constants (OFF_STATUS … OFF_SNAP_ALL);
  - CONTROL bit positions (CTL_ITO, CTL_CONT, CTL_START, CTL_STOP, CTL_PWM_EN);
  - STATUS bit positions.
- Sub-module dsd_timer_channel contains one channel's counter, RUN/TO logic, snapshot and PWM. The top instantiates it in a generate loop, decodes addresses and muxes readdata.

## Test plan
- Reset, then read offsets 0..4 of channel 0 → 0x0, 0x0, 49999, 0x0, 0x0. irq=0.
- ch1: PERIOD=9, CONTROL=0x7 (START|CONT|ITO) → TO every 10 cycles; irq_vec=0b0010 and irq=1. Write STATUS → TO clears, then re-asserts after the next timeout.
- ch2: PERIOD=4, START with CONT=0 → counts 4..0, then RUN=0 and count holds at 4 after reload. TO=1 exactly once.
- STATUS write in the same cycle as a ch1 timeout event → TO stays 1. CONTROL=0xC (START|STOP) → RUN=1.
- SNAP_ALL while ch0 and ch3 run with different periods → both snapshots equal each channel's count at that edge. A PERIOD write mid-run → RUN=0, count=new PERIOD.
- With DSD_TIMER_PWM_EN: ch0 PERIOD=9, COMPARE=3, PWM_EN|START|CONT → pwm_out[0] high 3 of every 10 cycles. Without the macro → pwm_out=0 and COMPARE reads 0.
